dh_shared_key: RTL and testbench
================================

Name: dh_shared_key

Overview:
Responder side of the Diffie-Hellman exchange. Takes the peer's public value R, the local private exponent x and the modulus p, and computes the shared key K = R^x mod p.
- Iterative, constant-time, left-to-right square-and-multiply.
- Each modular reduction is a restoring shift-subtract.
- Sits after the public-value generator and link receiver; feeds the key register/consumer through a valid/ready pair.

Parameters:
- WIDTH, 32, operand width of peer_pub, priv_key, modulus and key_out.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, can accept
- peer_pub  input  WIDTH  peer public value R
- priv_key  input  WIDTH  local private exponent x
- modulus  input  WIDTH  prime modulus p
- key_out  output  WIDTH  shared key K; stable while key_valid=1
- key_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- err  output  1  result invalid (qualified by key_valid)
- busy  output  1  computation in progress

Behaviour:
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; key_out=0, key_valid=0, err=0, busy=0.
  - All internal registers cleared; in_ready=1 after reset releases.
- in_ready = (state==IDLE). Accept on a rising edge with in_valid&&in_ready; peer_pub, priv_key and modulus are latched at that edge.
  - in_valid while not IDLE is ignored; a later change of the input values has no effect.
- States: IDLE, PRE, MUL, RED, DONE.
- IDLE -> PRE on accept.
  - If modulus==0: IDLE -> DONE instead, with err=1, key_out=0.
- PRE, exactly 2*WIDTH cycles: base = peer_pub mod p, by restoring reduction of the 2*WIDTH-bit value {0,peer_pub}, one quotient bit per cycle. Result register acc is set to 1. Then -> MUL.
- Bit loop: the exponent is scanned MSB to LSB over all WIDTH bits, with no skipping of leading zeros (constant time). Each bit performs two modmuls:
  - Modmul 1: acc = acc*acc mod p.
  - Modmul 2: acc = acc*(bit ? base : 1) mod p. The multiply and reduction are always executed.
- Modmul timing:
  - MUL, 1 cycle: 2*WIDTH-bit product registered.
  - RED, exactly 2*WIDTH cycles: shift-subtract reduction. Remainder stays < p; internal remainder is WIDTH+1 bits wide to hold the pre-subtract value.
- After the 2*WIDTH-th modmul -> DONE: key_out=acc, key_valid=1, err=0.
- Latency: accept at edge e0 -> key_valid high after edge e0 + 2W(2W+2). For W=32 that is 4224 cycles. Error path: key_valid high after edge e0+1.
- DONE output handshake:
  - key_valid, key_out and err are held until out_ready=1.
  - On that edge: key_valid=0, err=0, -> IDLE; in_ready=1 the next cycle.
  - out_ready outside DONE is ignored.
- busy=1 in PRE, MUL and RED; 0 otherwise.
- Boundary results:
  - priv_key=0 -> K=1 mod p, i.e. 1 (0 if p=1).
  - p=1 -> K=0, err=0.
  - peer_pub >= p -> reduced by PRE.
  - peer_pub mod p = 0 -> K=0 (x>0).

Optional Feature:
Macro DH_PUBKEY_CHECK_EN.
- Defined: at accept, peer_pub is rejected if it equals 0 or 1, is >= modulus, or equals modulus-1.
  - Rejection -> DONE next edge with err=1, key_out=0.
  - The modulus==0 check also applies and gives the same err response.
- Undefined: no validation; peer_pub is reduced mod p and used as-is.

Test Plan:
- p=23, peer_pub=19, priv_key=6 -> key_out=2, err=0, key_valid exactly 4224 cycles after accept; in_ready low throughout.
- p=23, peer_pub=8, priv_key=15 -> key_out=2, matching the first case. Then hold out_ready=0 for 10 cycles -> key_out stays 2 and key_valid stays 1 until out_ready=1.
- p=23, peer_pub=19, priv_key=0 -> key_out=1. p=1, peer_pub=5, priv_key=3 -> key_out=0, err=0.
- modulus=0 -> key_valid the cycle after accept, err=1, key_out=0. Pulsing in_valid with new operands while busy -> no effect on the in-flight result.
- p=0xFFFFFFFB, peer_pub=0xFFFFFFFF, priv_key=2:
  - Macro undefined -> key_out=16.
  - Macro defined -> err=1.
  - Macro undefined, p=23, peer_pub=30, priv_key=1 -> key_out=7.
- Assert rst=0 mid-RED -> all outputs 0 immediately, in_ready=1 after release. A new run with p=23, peer_pub=5, priv_key=6 -> key_out=8.

Source files
------------

// File: rtl/dh_shared_key.sv
// dh_shared_key: responder-side Diffie-Hellman shared key, K = peer_pub^priv_key mod modulus.
// Iterative, constant-time, left-to-right square-and-multiply. Every modular reduction
// is a restoring shift-subtract that produces one quotient bit per cycle.
// Optional build macro DH_PUBKEY_CHECK_EN: when defined, degenerate peer public values
// (0, 1, >= modulus, modulus-1) are rejected at accept with err=1.
module dh_shared_key #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] peer_pub,
    input  logic [WIDTH-1:0] priv_key,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] key_out,
    output logic             key_valid,
    input  logic             out_ready,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam int BW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, PRE, MUL, RED, DONE} state_t;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   div_reg;      // dividend being shifted out MSB first
    logic [WIDTH-1:0]     rem_reg;      // running remainder, always < modulus
    logic [WIDTH-1:0]     mod_reg;
    logic [WIDTH-1:0]     exp_reg;      // exponent, current bit at MSB
    logic [WIDTH-1:0]     base_reg;
    logic [WIDTH-1:0]     acc_reg;
    logic [WIDTH-1:0]     key_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_reg;      // exponent bits still to process, minus one
    logic                 phase_reg;    // 0: squaring modmul, 1: conditional multiply
    logic                 valid_reg;
    logic                 err_reg;
    logic                 err_pend_reg; // rejected operands: raise err one cycle after accept

    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   product;
    logic                 reject;
    logic                 red_last;

    // One restoring reduction step: shift in the next dividend bit, subtract if it fits.
    // trial is one bit wider than the remainder so the pre-subtract value cannot overflow.
    always_comb begin
        trial    = {rem_reg, div_reg[2*WIDTH-1]};
        rem_next = WIDTH'((trial >= {1'b0, mod_reg}) ? (trial - {1'b0, mod_reg}) : trial);
    end

    // Multiplier operand: square first, then multiply by base or by 1 so both
    // exponent-bit values cost the same time.
    always_comb begin
        mul_b   = phase_reg ? (exp_reg[WIDTH-1] ? base_reg : ONE) : acc_reg;
        product = (2 * WIDTH)'(acc_reg) * (2 * WIDTH)'(mul_b);
    end

    // Operand screening at accept time.
    always_comb begin
`ifdef DH_PUBKEY_CHECK_EN
        reject = (modulus == '0) || (peer_pub < WIDTH'(2)) ||
                 (peer_pub >= modulus) || (peer_pub == modulus - ONE);
`else
        reject = (modulus == '0);
`endif
    end

    assign red_last  = (cnt_reg == CW'(2 * WIDTH - 1));
    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == PRE) || (state_reg == MUL) || (state_reg == RED);
    assign key_out   = key_reg;
    assign key_valid = valid_reg;
    assign err       = err_reg;

    // Main sequencer: operand capture, base pre-reduction, modmul loop and output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            rem_reg      <= '0;
            mod_reg      <= '0;
            exp_reg      <= '0;
            base_reg     <= '0;
            acc_reg      <= '0;
            key_reg      <= '0;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            phase_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        mod_reg   <= modulus;
                        exp_reg   <= priv_key;
                        div_reg   <= {{WIDTH{1'b0}}, peer_pub};
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        bit_reg   <= BW'(WIDTH - 1);
                        phase_reg <= 1'b0;
                        if (reject) begin
                            err_pend_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            state_reg <= PRE;
                        end
                    end
                end
                PRE: begin
                    rem_reg <= rem_next;
                    div_reg <= div_reg << 1;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (red_last) begin
                        base_reg  <= rem_next;
                        acc_reg   <= ONE;
                        state_reg <= MUL;
                    end
                end
                MUL: begin
                    div_reg   <= product;
                    rem_reg   <= '0;
                    cnt_reg   <= '0;
                    state_reg <= RED;
                end
                RED: begin
                    rem_reg <= rem_next;
                    div_reg <= div_reg << 1;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (red_last) begin
                        acc_reg   <= rem_next;
                        phase_reg <= ~phase_reg;
                        state_reg <= MUL;
                        if (phase_reg) begin
                            exp_reg <= exp_reg << 1;
                            bit_reg <= bit_reg - BW'(1);
                            if (bit_reg == '0) begin
                                key_reg   <= rem_next;
                                valid_reg <= 1'b1;
                                err_reg   <= 1'b0;
                                state_reg <= DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    if (err_pend_reg) begin
                        err_pend_reg <= 1'b0;
                        key_reg      <= '0;
                        valid_reg    <= 1'b1;
                        err_reg      <= 1'b1;
                    end else if (valid_reg && out_ready) begin
                        valid_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dh_shared_key.sv
// tb_dh_shared_key: table-driven bench with a scoreboard queue for dh_shared_key (WIDTH=32).
module tb_dh_shared_key;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] peer_pub;
    logic [31:0] priv_key;
    logic [31:0] modulus;
    logic [31:0] key_out;
    logic        key_valid;
    logic        out_ready;
    logic        err;
    logic        busy;

    dh_shared_key #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .peer_pub  (peer_pub),
        .priv_key  (priv_key),
        .modulus   (modulus),
        .key_out   (key_out),
        .key_valid (key_valid),
        .out_ready (out_ready),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] p;
        logic [31:0] r;
        logic [31:0] x;
        logic [31:0] k;
        logic        e;
        logic        hold;
        logic        pulse;
    } vec_t;

    vec_t tbl[8];
    vec_t exp_q[$];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit pub_bad(input logic [31:0] p, input logic [31:0] r);
`ifdef DH_PUBKEY_CHECK_EN
        return (p == 0) || (r < 2) || (r >= p) || (r == p - 1);
`else
        return (p == 0);
`endif
    endfunction

    // Drive one transaction, wait for the result and compare it against the scoreboard.
    task automatic run(input vec_t v);
        vec_t e;
        int   cyc;
        bit   rdy_bad;
        e = v;
        if (pub_bad(v.p, v.r)) begin
            e.k = 32'd0;
            e.e = 1'b1;
        end
        exp_q.push_back(e);
        peer_pub = v.r;
        priv_key = v.x;
        modulus  = v.p;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        peer_pub = 32'hDEAD_BEEF;
        priv_key = 32'h1234_5678;
        modulus  = 32'h0000_0011;
        cyc      = 0;
        rdy_bad  = 1'b0;
        while (!key_valid && cyc < 5000) begin
            if (in_ready) rdy_bad = 1'b1;
            if (v.pulse) begin
                in_valid = (cyc == 10 || cyc == 11);
                peer_pub = 32'd3;
                priv_key = 32'd5;
                modulus  = 32'd7;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        e = exp_q.pop_front();
        check("in_ready_low_while_running", {31'd0, rdy_bad}, 32'd0);
        check("latency", cyc, e.e ? 32'd1 : 32'd4224);
        check("key_valid", {31'd0, key_valid}, 32'd1);
        check("key_out", key_out, e.k);
        check("err", {31'd0, err}, {31'd0, e.e});
        $display("txn p=%0h r=%0h x=%0h key=%0h err=%0b lat=%0d", v.p, v.r, v.x, key_out, err, cyc);
        if (v.hold) begin
            repeat (10) begin
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, key_valid}, 32'd1);
                check("hold_key", key_out, e.k);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_cleared", {31'd0, key_valid}, 32'd0);
        check("err_cleared", {31'd0, err}, 32'd0);
        check("ready_after_handshake", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vec_t v;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        peer_pub  = '0;
        priv_key  = '0;
        modulus   = '0;

        //            p              r              x         k       e     hold  pulse
        tbl[0] = '{32'd23,        32'd19,        32'd6,  32'd2,  1'b0, 1'b0, 1'b1};
        tbl[1] = '{32'd23,        32'd8,         32'd15, 32'd2,  1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'd23,        32'd19,        32'd0,  32'd1,  1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'd1,         32'd5,         32'd3,  32'd0,  1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'd0,         32'd7,         32'd3,  32'd0,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{32'hFFFFFFFB,  32'hFFFFFFFF,  32'd2,  32'd16, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'd23,        32'd30,        32'd1,  32'd7,  1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'd23,        32'd5,         32'd6,  32'd8,  1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_key_valid", {31'd0, key_valid}, 32'd0);
        check("reset_key_out", key_out, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 7; i++) run(tbl[i]);

        // Abort a computation in the middle of a reduction with an asynchronous reset.
        peer_pub = 32'd5;
        priv_key = 32'd6;
        modulus  = 32'd23;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("busy_mid_run", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_valid", {31'd0, key_valid}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        check("async_rst_key", key_out, 32'd0);
        $display("txn async reset mid-reduction");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        check("busy_after_rst", {31'd0, busy}, 32'd0);

        v = tbl[7];
        run(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
